// File: rtl/ls_down_counter_pkg.sv
// Shared constants for the cascadable down-counter and its 4-bit stages.
package ls_down_counter_pkg;

    localparam int         NIBBLE_W    = 4;
    localparam logic [3:0] NIBBLE_ZERO = 4'h0;
    localparam logic [3:0] NIBBLE_ONES = 4'hF;

endpackage

// File: rtl/ls_down_nibble.sv
// One 4-bit down-counting stage: clear > load > count > hold, borrow out when empty.
module ls_down_nibble
    import ls_down_counter_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    input  logic [NIBBLE_W-1:0] d,
    input  logic                load_n,
    input  logic                enp,
    input  logic                ent,
    output logic [NIBBLE_W-1:0] q,
    output logic                bro
);

    logic is_zero;

    assign is_zero = (q == NIBBLE_ZERO);
    assign bro     = ent && is_zero;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= NIBBLE_ZERO;
        end else if (!load_n) begin
            q <= d;
        end else if (enp && ent) begin
            q <= is_zero ? NIBBLE_ONES : q - 4'd1;
        end
    end

endmodule

// File: rtl/ls_down_counter.sv
// Cascadable down-counter built from ls_down_nibble stages, with reload register and underflow pulse.
module ls_down_counter
    import ls_down_counter_pkg::*;
#(
    parameter int NIBBLES = 2
)
(
    input  logic                    CLK,
    input  logic                    CLR,
    input  logic [4*NIBBLES-1:0]    D,
    input  logic                    LOAD_n,
    input  logic                    ENP,
    input  logic                    ENT,
    input  logic                    AUTO_RELOAD,
    output logic [4*NIBBLES-1:0]    Q,
    output logic                    BRO,
    output logic                    TC_PULSE
);

    localparam int W = NIBBLES * NIBBLE_W;

    logic [W-1:0]     rld;
    logic [NIBBLES:0] ent_chain;
    logic             underflow;
    logic             reload;
    logic             stage_load_n;
    logic [W-1:0]     stage_d;

    assign underflow = LOAD_n && ENP && ENT && (Q == '0);
    assign reload    = underflow && AUTO_RELOAD;

    // Auto-reload reuses the stages' parallel-load path, sourcing it from RLD.
    assign stage_load_n = LOAD_n && !reload;
    assign stage_d      = LOAD_n ? rld : D;

    assign ent_chain[0] = ENT;
    assign BRO          = ent_chain[NIBBLES];

    for (genvar k = 0; k < NIBBLES; k++) begin : g_nib
        ls_down_nibble u_nib (
            .clk    (CLK),
            .clr    (CLR),
            .d      (stage_d[k*NIBBLE_W +: NIBBLE_W]),
            .load_n (stage_load_n),
            .enp    (ENP),
            .ent    (ent_chain[k]),
            .q      (Q[k*NIBBLE_W +: NIBBLE_W]),
            .bro    (ent_chain[k+1])
        );
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            rld      <= '0;
            TC_PULSE <= 1'b0;
        end else begin
            if (!LOAD_n) begin
                rld <= D;
            end
            TC_PULSE <= underflow;
        end
    end

endmodule

// File: tb/tb_ls_down_counter.sv
// Self-checking bench: directed scenarios plus random stimulus against a behavioural model.
module tb_ls_down_counter;

    logic       CLK = 1'b0;
    logic       CLR;
    logic [7:0] D;
    logic       LOAD_n;
    logic       ENP;
    logic       ENT;
    logic       AUTO_RELOAD;
    logic [7:0] Q;
    logic       BRO;
    logic       TC_PULSE;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q_m;
    logic [7:0] rld_m;
    logic       tc_m;

    ls_down_counter #(.NIBBLES(2)) dut (
        .CLK         (CLK),
        .CLR         (CLR),
        .D           (D),
        .LOAD_n      (LOAD_n),
        .ENP         (ENP),
        .ENT         (ENT),
        .AUTO_RELOAD (AUTO_RELOAD),
        .Q           (Q),
        .BRO         (BRO),
        .TC_PULSE    (TC_PULSE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_m   = 8'h00;
        rld_m = 8'h00;
        tc_m  = 1'b0;
    endtask

    // Behavioural model of one rising edge.
    task automatic model_edge();
        if (!LOAD_n) begin
            q_m   = D;
            rld_m = D;
            tc_m  = 1'b0;
        end else if (ENP && ENT) begin
            if (q_m == 8'h00) begin
                q_m  = AUTO_RELOAD ? rld_m : 8'hFF;
                tc_m = 1'b1;
            end else begin
                q_m  = q_m - 8'd1;
                tc_m = 1'b0;
            end
        end else begin
            tc_m = 1'b0;
        end
    endtask

    // Called just after a falling edge: drive, check BRO, clock, check Q/TC/RLD.
    task automatic step(input logic ld_n, input logic [7:0] dv, input logic p,
                        input logic t, input logic ar);
        LOAD_n      = ld_n;
        D           = dv;
        ENP         = p;
        ENT         = t;
        AUTO_RELOAD = ar;
        #1;
        check("bro", {15'd0, BRO}, {15'd0, (t && q_m == 8'h00)});
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check("q",   {8'd0, Q}, {8'd0, q_m});
        check("tc",  {15'd0, TC_PULSE}, {15'd0, tc_m});
        check("rld", {8'd0, dut.rld}, {8'd0, rld_m});
    endtask

    task automatic count(input int n, input logic ar);
        for (int i = 0; i < n; i++) step(1'b1, 8'h00, 1'b1, 1'b1, ar);
    endtask

    initial begin
        CLR = 1'b1; D = 8'h5A; LOAD_n = 1'b0; ENP = 1'b1; ENT = 1'b0; AUTO_RELOAD = 1'b1;
        model_reset();

        // Reset holds everything at zero regardless of inputs.
        repeat (2) @(negedge CLK);
        check("rst_q",  {8'd0, Q}, 16'h0000);
        check("rst_tc", {15'd0, TC_PULSE}, 16'h0000);
        check("rst_bro0", {15'd0, BRO}, 16'h0000);
        ENT = 1'b1;
        #1;
        check("rst_bro1", {15'd0, BRO}, 16'h0001);
        @(negedge CLK);
        CLR = 1'b0;

        // Load and borrow across nibbles.
        step(1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
        count(1, 1'b0);
        check("borrow_0f", {8'd0, Q}, 16'h000F);
        count(1, 1'b0);
        check("borrow_0e", {8'd0, Q}, 16'h000E);

        // Wrap mode underflow.
        step(1'b0, 8'h02, 1'b1, 1'b1, 1'b0);
        count(3, 1'b0);
        check("wrap_ff", {8'd0, Q}, 16'h00FF);
        check("wrap_tc", {15'd0, TC_PULSE}, 16'h0001);
        count(1, 1'b0);
        check("wrap_tc_off", {15'd0, TC_PULSE}, 16'h0000);

        // Reload mode underflow.
        step(1'b0, 8'h03, 1'b1, 1'b1, 1'b1);
        count(4, 1'b1);
        check("reload_03", {8'd0, Q}, 16'h0003);
        check("reload_tc", {15'd0, TC_PULSE}, 16'h0001);
        count(4, 1'b1);

        // Enable gating at 05.
        step(1'b0, 8'h05, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h00, i[0], ~i[0], 1'b0);
        check("hold_05", {8'd0, Q}, 16'h0005);

        // BRO at zero with every enable combination.
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        step(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b1);

        // Load beats underflow.
        step(1'b0, 8'hA5, 1'b1, 1'b1, 1'b1);
        check("ldwin_q",  {8'd0, Q}, 16'h00A5);
        check("ldwin_tc", {15'd0, TC_PULSE}, 16'h0000);

        // RLD == 0 in reload mode fires every enabled edge.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        count(3, 1'b1);

        // Asynchronous clear mid-count at 37.
        step(1'b0, 8'h37, 1'b0, 1'b0, 1'b0);
        LOAD_n = 1'b1; ENP = 1'b1; ENT = 1'b1;
        #2;
        CLR = 1'b1;
        #1;
        check("aclr_q",  {8'd0, Q}, 16'h0000);
        check("aclr_tc", {15'd0, TC_PULSE}, 16'h0000);
        model_reset();
        @(negedge CLK);
        CLR = 1'b0;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] dv;
            dv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            if ($urandom_range(0, 60) == 0) begin
                #2;
                CLR = 1'b1;
                #1;
                check("rand_aclr", {8'd0, Q}, 16'h0000);
                model_reset();
                @(negedge CLK);
                CLR = 1'b0;
            end
            step(($urandom_range(0, 7) != 0), dv, ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 4) != 0), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
